// File: rtl/dtw_host_xactor.sv
// Host-side transactor for a DTW engine: it owns the shared template/result
// memory, buffers host samples in a FIFO, streams them to the engine, and
// counts the engine's result writes to decide when a run has finished.
module dtw_host_xactor #(
  parameter int FIFO_DEPTH = 16,
  parameter int MEM_WORDS  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_we_i,
  input  logic [9:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_ready_o,
  input  logic        smp_valid_i,
  input  logic [31:0] smp_data_i,
  output logic        smp_ready_o,
  input  logic [4:0]  cfg_len_i,
  input  logic [9:0]  cfg_wr_len_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [10:0] wr_cnt_o,
  input  logic [9:0]  addr_i,
  input  logic        CS_i,
  input  logic        WR_i,
  input  logic        data_tri_ena_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] Sin_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [31:0]   r_mem  [MEM_WORDS];
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [4:0]    r_sentCnt;
  logic [10:0]   r_wrCnt;
  logic [31:0]   r_dataO;

  logic w_live;
  logic w_start;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_hostWr;
  logic w_dtwWr;
  logic w_dtwRd;
  logic w_lastSample;
  logic w_lastWrite;

  // The engine owns the memory port while a run is live, so the host is locked out then.
  assign w_live       = (r_state == S_RUN) || (r_state == S_WAIT);
  assign w_start      = start_i && !w_live;
  assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = smp_valid_i && !w_full;
  assign w_pop        = valid_o && ready_i;
  assign w_hostWr     = host_we_i && !w_live;
  assign w_dtwWr      = CS_i && WR_i && data_tri_ena_i;
  assign w_dtwRd      = CS_i && !WR_i;
  assign w_lastSample = w_pop && (r_sentCnt == cfg_len_i);
  assign w_lastWrite  = w_live && w_dtwWr && (r_wrCnt == {1'b0, cfg_wr_len_i});

  assign host_ready_o = !w_live;
  assign smp_ready_o  = !w_full;
  assign busy_o       = w_live;
  assign done_o       = (r_state == S_DONE);
  assign wr_cnt_o     = r_wrCnt;
  assign data_o       = r_dataO;
  assign valid_o      = (r_state == S_RUN) && !w_empty;
  assign Sin_o        = w_empty ? 32'd0 : r_fifo[r_rdPtr];

  // State register; reset always returns to IDLE, aborting any run.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next state: the final engine write wins over the final sample in the same cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_nextState = S_RUN;
      S_RUN: begin
        if (w_lastWrite)       w_nextState = S_DONE;
        else if (w_lastSample) w_nextState = S_WAIT;
      end
      S_WAIT: if (w_lastWrite) w_nextState = S_DONE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Run counters: samples sent and engine writes captured; the write count saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start) begin
      r_sentCnt <= '0;
      r_wrCnt   <= '0;
    end else begin
      if (w_pop) r_sentCnt <= r_sentCnt + 5'd1;
      if (w_live && w_dtwWr && (r_wrCnt != 11'd2047)) r_wrCnt <= r_wrCnt + 11'd1;
    end
  end

  // Shared memory write port; contents survive reset, host has priority outside a run.
  always_ff @(posedge clk_i) begin
    if (w_hostWr)     r_mem[host_addr_i] <= host_wdata_i;
    else if (w_dtwWr) r_mem[addr_i]      <= data_i;
  end

  // Engine read port with one cycle of latency; the last word read is held.
  always_ff @(posedge clk_i) begin
    if (rst_i)        r_dataO <= '0;
    else if (w_dtwRd) r_dataO <= r_mem[addr_i];
  end

  // Sample FIFO storage; empty slots are masked on Sin_o, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wrPtr] <= smp_data_i;
  end

  // FIFO pointers wrap naturally at the power-of-two depth; push+pop keeps occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_host_xactor.sv
// Directed bench for dtw_host_xactor: preload, streaming, completion,
// FIFO limits, host lockout and mid-run reset, checked against hand values.
module tb_dtw_host_xactor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        host_we_i = 1'b0;
  logic [9:0]  host_addr_i = '0;
  logic [31:0] host_wdata_i = '0;
  logic        host_ready_o;
  logic        smp_valid_i = 1'b0;
  logic [31:0] smp_data_i = '0;
  logic        smp_ready_o;
  logic [4:0]  cfg_len_i = '0;
  logic [9:0]  cfg_wr_len_i = '0;
  logic        start_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [10:0] wr_cnt_o;
  logic [9:0]  addr_i = '0;
  logic        CS_i = 1'b0;
  logic        WR_i = 1'b0;
  logic        data_tri_ena_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [31:0] Sin_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model[$];

  dtw_host_xactor #(.FIFO_DEPTH(16), .MEM_WORDS(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_ready_o(host_ready_o),
    .smp_valid_i(smp_valid_i), .smp_data_i(smp_data_i), .smp_ready_o(smp_ready_o),
    .cfg_len_i(cfg_len_i), .cfg_wr_len_i(cfg_wr_len_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .wr_cnt_o(wr_cnt_o),
    .addr_i(addr_i), .CS_i(CS_i), .WR_i(WR_i), .data_tri_ena_i(data_tri_ena_i),
    .data_i(data_i), .data_o(data_o), .Sin_o(Sin_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  // Free-running clock, 10 ns period.
  always #5 clk_i = ~clk_i;

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic ena, input logic [9:0] addr, input logic [31:0] data);
    CS_i = 1'b1;
    WR_i = wr;
    data_tri_ena_i = ena;
    addr_i = addr;
    data_i = data;
    stepCycle();
    CS_i = 1'b0;
    WR_i = 1'b0;
    data_tri_ena_i = 1'b0;
  endtask

  task automatic dtwRead(input string tag, input logic [9:0] addr, input logic [31:0] expected);
    applyStimulus(1'b0, 1'b0, addr, 32'd0);
    checkOutput(tag, data_o, expected);
  endtask

  task automatic hostWrite(input logic [9:0] addr, input logic [31:0] data);
    host_we_i = 1'b1;
    host_addr_i = addr;
    host_wdata_i = data;
    stepCycle();
    host_we_i = 1'b0;
  endtask

  task automatic pushSample(input logic [31:0] data);
    smp_valid_i = 1'b1;
    smp_data_i = data;
    if (model.size() < 16) model.push_back(data);
    stepCycle();
    smp_valid_i = 1'b0;
  endtask

  task automatic popCheck(input string tag);
    logic [31:0] head;
    head = (model.size() > 0) ? model.pop_front() : 32'hDEAD_BEEF;
    ready_i = 1'b1;
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
    checkOutput(tag, Sin_o, head);
    stepCycle();
    ready_i = 1'b0;
  endtask

  // Safety net in case the design stops responding.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    int          k;
    logic        hs;
    logic [31:0] tmp;

    stepCycle();
    stepCycle();
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_hostrdy", 32'(host_ready_o), 32'd1);
    checkOutput("rst_smprdy", 32'(smp_ready_o), 32'd1);
    checkOutput("rst_wrcnt", 32'(wr_cnt_o), 32'd0);
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_sin", Sin_o, 32'd0);
    rst_i = 1'b0;
    stepCycle();

    hostWrite(10'd5, 32'h0000_002A);
    hostWrite(10'd7, 32'h0000_0077);
    hostWrite(10'd13, 32'h0000_0055);
    dtwRead("preload_rd", 10'd5, 32'h0000_002A);
    stepCycle();
    checkOutput("rd_hold", data_o, 32'h0000_002A);

    for (int i = 0; i < 4; i++) pushSample(32'h100 + 32'(i));
    checkOutput("idle_valid", 32'(valid_o), 32'd0);
    cfg_len_i = 5'd3;
    cfg_wr_len_i = 10'd2;
    start_i = 1'b1;
    stepCycle();
    start_i = 1'b0;
    checkOutput("run_busy", 32'(busy_o), 32'd1);
    checkOutput("run_hostrdy", 32'(host_ready_o), 32'd0);

    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      ready_i = (i % 2 == 0);
      if (valid_o) checkOutput("stream_sin", Sin_o, 32'h100 + 32'(k));
      hs = valid_o && ready_i;
      stepCycle();
      if (hs) begin
        k++;
        tmp = model.pop_front();
      end
    end
    ready_i = 1'b0;
    checkOutput("stream_count", 32'(k), 32'd4);
    checkOutput("wait_valid", 32'(valid_o), 32'd0);
    checkOutput("wait_busy", 32'(busy_o), 32'd1);

    host_we_i = 1'b1;
    host_addr_i = 10'd7;
    host_wdata_i = 32'h0000_DEAD;
    checkOutput("lock_hostrdy", 32'(host_ready_o), 32'd0);
    stepCycle();
    host_we_i = 1'b0;
    dtwRead("lock_mem", 10'd7, 32'h0000_0077);

    pushSample(32'h200);
    checkOutput("wait_push_valid", 32'(valid_o), 32'd0);
    start_i = 1'b1;
    stepCycle();
    start_i = 1'b0;
    checkOutput("wait_start_valid", 32'(valid_o), 32'd0);
    checkOutput("wait_start_busy", 32'(busy_o), 32'd1);
    checkOutput("wait_start_done", 32'(done_o), 32'd0);

    applyStimulus(1'b1, 1'b1, 10'd10, 32'hA0);
    checkOutput("wr1_cnt", 32'(wr_cnt_o), 32'd1);
    applyStimulus(1'b1, 1'b0, 10'd13, 32'hBAD);
    checkOutput("wr_noena_cnt", 32'(wr_cnt_o), 32'd1);
    applyStimulus(1'b1, 1'b1, 10'd11, 32'hA1);
    checkOutput("wr2_cnt", 32'(wr_cnt_o), 32'd2);
    checkOutput("wr2_done", 32'(done_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 10'd12, 32'hA2);
    checkOutput("wr3_cnt", 32'(wr_cnt_o), 32'd3);
    checkOutput("wr3_done", 32'(done_o), 32'd1);
    checkOutput("wr3_busy", 32'(busy_o), 32'd0);
    checkOutput("wr3_hostrdy", 32'(host_ready_o), 32'd1);
    dtwRead("mem10", 10'd10, 32'hA0);
    dtwRead("mem11", 10'd11, 32'hA1);
    dtwRead("mem12", 10'd12, 32'hA2);
    dtwRead("mem13_noena", 10'd13, 32'h55);
    stepCycle();
    checkOutput("done_sticky", 32'(done_o), 32'd1);
    checkOutput("done_valid", 32'(valid_o), 32'd0);

    for (int i = 1; i < 16; i++) pushSample(32'h300 + 32'(i));
    checkOutput("full_smprdy", 32'(smp_ready_o), 32'd0);
    pushSample(32'hFFF);
    cfg_len_i = 5'd31;
    start_i = 1'b1;
    stepCycle();
    start_i = 1'b0;
    checkOutput("restart_done", 32'(done_o), 32'd0);
    checkOutput("restart_wrcnt", 32'(wr_cnt_o), 32'd0);
    for (int i = 0; i < 8; i++) popCheck("drain_a");
    checkOutput("half_smprdy", 32'(smp_ready_o), 32'd1);

    smp_valid_i = 1'b1;
    smp_data_i = 32'h400;
    ready_i = 1'b1;
    tmp = model.pop_front();
    checkOutput("pp_sin", Sin_o, tmp);
    model.push_back(32'h400);
    stepCycle();
    smp_valid_i = 1'b0;
    ready_i = 1'b0;
    for (int i = 0; i < 7; i++) pushSample(32'h410 + 32'(i));
    checkOutput("occ15_smprdy", 32'(smp_ready_o), 32'd1);
    pushSample(32'h417);
    checkOutput("occ16_smprdy", 32'(smp_ready_o), 32'd0);
    for (int i = 0; i < 16; i++) popCheck("drain_b");
    checkOutput("drained_valid", 32'(valid_o), 32'd0);
    checkOutput("drained_busy", 32'(busy_o), 32'd1);

    host_we_i = 1'b1;
    host_addr_i = 10'd5;
    host_wdata_i = 32'h0000_BEEF;
    checkOutput("run_lock_hostrdy", 32'(host_ready_o), 32'd0);
    stepCycle();
    host_we_i = 1'b0;

    for (int i = 0; i < 4; i++) pushSample(32'h500 + 32'(i));
    popCheck("abort_pop");
    popCheck("abort_pop");
    ready_i = 1'b1;
    rst_i = 1'b1;
    stepCycle();
    checkOutput("abort_valid", 32'(valid_o), 32'd0);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_done", 32'(done_o), 32'd0);
    checkOutput("abort_smprdy", 32'(smp_ready_o), 32'd1);
    checkOutput("abort_sin", Sin_o, 32'd0);
    checkOutput("abort_hostrdy", 32'(host_ready_o), 32'd1);
    rst_i = 1'b0;
    model.delete();
    stepCycle();
    checkOutput("abort_valid_after", 32'(valid_o), 32'd0);
    ready_i = 1'b0;
    dtwRead("abort_mem", 10'd5, 32'h0000_002A);
    pushSample(32'h600);
    checkOutput("abort_fifo_head", Sin_o, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
